// File: rtl/wordcount_batch_ctrl_if.sv
// Key stream carrying LANES packed keys per beat from the read master to the batch controller.
// Source drives master; the controller consumes through slave.
interface wordcount_batch_ctrl_if #(
  parameter int unsigned DATA_W = 512
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/wordcount_batch_ctrl.sv
// Splits a word-count job into engine batches: pages reads, unpacks stream beats into keys.
// Define BATCH_CTRL_PERF_EN to add saturating perf_beats / perf_batches counters.
module wordcount_batch_ctrl #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned KEY_W      = 128,
  parameter int unsigned MAX_WORDS  = 16,
  parameter int unsigned PAGE_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       num_of_words,
  input  logic [63:0]       memory_offset,
  output logic              rd_start,
  output logic [63:0]       rd_addr,
  output logic [31:0]       rd_bytes,
  input  logic              rd_done,
  wordcount_batch_ctrl_if.slave s_if,
  output logic              eng_we,
  output logic [KEY_W+31:0] eng_din,
  input  logic              eng_full,
  output logic              eng_kick,
  output logic [7:0]        eng_data_num,
`ifdef BATCH_CTRL_PERF_EN
  output logic [31:0]       perf_beats,
  output logic [31:0]       perf_batches,
`endif
  input  logic              eng_busy
);
  localparam int unsigned LANES      = DATA_W / KEY_W;
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned LANE_W     = $clog2(LANES + 1);
  // lane_q == LANES marks the beat buffer as empty
  localparam logic [LANE_W-1:0] LaneEmpty = LANE_W'(LANES);

  typedef enum logic [2:0] {StIdle, StIssue, StFetch, StEmit, StKick, StWait} state_e;

  state_e              state_q, state_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [7:0]          target_q, target_d;
  logic [31:0]         index_q, index_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   beat_q, beat_d;
  logic [63:0]         offset_q, offset_d;
  logic [63:0]         bytes_left_q, bytes_left_d;
  logic [31:0]         page_rest_q, page_rest_d;
  logic [7:0]          batch_cnt_q, batch_cnt_d;
  logic                s_ready;
  logic [7:0]          batch_size;
  logic [KEY_W-1:0]    lane_key;
  logic                unused_rd_done;

  assign unused_rd_done = rd_done;
  assign busy           = (state_q != StIdle);
  assign rd_addr        = offset_q;
  assign rd_bytes       = (bytes_left_q > 64'(PAGE_BYTES)) ? 32'(PAGE_BYTES) : bytes_left_q[31:0];
  assign batch_size     = (remaining_q >= 32'(MAX_WORDS)) ? 8'(MAX_WORDS) : remaining_q[7:0];
  assign eng_din        = {index_q, lane_key};
  assign eng_data_num   = batch_cnt_q;
  assign s_if.s_ready   = s_ready;

  always_comb begin
    lane_key = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_q == LANE_W'(i)) lane_key = beat_q[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    target_d     = target_q;
    index_d      = index_q;
    lane_d       = lane_q;
    beat_d       = beat_q;
    offset_d     = offset_q;
    bytes_left_d = bytes_left_q;
    page_rest_d  = page_rest_q;
    batch_cnt_d  = batch_cnt_q;
    rd_start     = 1'b0;
    s_ready      = 1'b0;
    eng_we       = 1'b0;
    eng_kick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (kick) begin
          remaining_d  = num_of_words;
          offset_d     = memory_offset;
          bytes_left_d = ((64'(num_of_words) + 64'(LANES - 1)) / 64'(LANES)) * 64'(BEAT_BYTES);
          index_d      = '0;
          page_rest_d  = '0;
          target_d     = '0;
          batch_cnt_d  = '0;
          lane_d       = LaneEmpty;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        // target_q == 0 starts a new batch; otherwise this is a mid-batch page check
        if (target_q == 8'd0 && remaining_q == 32'd0) begin
          state_d = StIdle;
        end else begin
          if (target_q == 8'd0) begin
            target_d    = batch_size;
            remaining_d = remaining_q - 32'(batch_size);
            state_d     = (lane_q == LaneEmpty) ? StFetch : StEmit;
          end else begin
            state_d = StFetch;
          end
          if (page_rest_q == 32'd0 && bytes_left_q != 64'd0) begin
            rd_start     = 1'b1;
            offset_d     = offset_q + 64'(rd_bytes);
            bytes_left_d = bytes_left_q - 64'(rd_bytes);
            page_rest_d  = rd_bytes;
          end
        end
      end
      StFetch: begin
        s_ready = 1'b1;
        if (s_if.s_valid) begin
          beat_d      = s_if.s_data;
          page_rest_d = page_rest_q - 32'(BEAT_BYTES);
          lane_d      = '0;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (!eng_full) begin
          eng_we      = 1'b1;
          index_d     = index_q + 32'd1;
          lane_d      = lane_q + LANE_W'(1);
          target_d    = target_q - 8'd1;
          batch_cnt_d = batch_cnt_q + 8'd1;
          if (target_q == 8'd1) state_d = StKick;
          else if (lane_q == LANE_W'(LANES - 1)) state_d = StIssue;
        end
      end
      StKick: begin
        eng_kick    = 1'b1;
        batch_cnt_d = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (!eng_busy) state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      target_q     <= '0;
      index_q      <= '0;
      lane_q       <= LaneEmpty;
      beat_q       <= '0;
      offset_q     <= '0;
      bytes_left_q <= '0;
      page_rest_q  <= '0;
      batch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      target_q     <= target_d;
      index_q      <= index_d;
      lane_q       <= lane_d;
      beat_q       <= beat_d;
      offset_q     <= offset_d;
      bytes_left_q <= bytes_left_d;
      page_rest_q  <= page_rest_d;
      batch_cnt_q  <= batch_cnt_d;
    end
  end

`ifdef BATCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state_q == StIdle && kick)) begin
      perf_beats   <= '0;
      perf_batches <= '0;
    end else begin
      if (s_if.s_valid && s_ready && perf_beats != '1) perf_beats <= perf_beats + 32'd1;
      if (eng_kick && perf_batches != '1) perf_batches <= perf_batches + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wordcount_batch_ctrl.sv
// Randomized bench for wordcount_batch_ctrl: a queue-based job model predicts reads, writes, kicks.
module tb_wordcount_batch_ctrl;
  localparam int unsigned DATA_W     = 512;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned MAX_WORDS  = 16;
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned LANES      = DATA_W / KEY_W;
  localparam int unsigned BEAT_BYTES = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              kick = 1'b0;
  logic              busy;
  logic [31:0]       num_of_words = '0;
  logic [63:0]       memory_offset = '0;
  logic              rd_start;
  logic [63:0]       rd_addr;
  logic [31:0]       rd_bytes;
  logic              rd_done = 1'b0;
  logic              eng_we;
  logic [KEY_W+31:0] eng_din;
  logic              eng_full = 1'b0;
  logic              eng_kick;
  logic [7:0]        eng_data_num;
  logic              eng_busy = 1'b0;
`ifdef BATCH_CTRL_PERF_EN
  logic [31:0]       perf_beats;
  logic [31:0]       perf_batches;
`endif

  wordcount_batch_ctrl_if #(.DATA_W(DATA_W)) s_if ();

  wordcount_batch_ctrl #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .MAX_WORDS(MAX_WORDS), .PAGE_BYTES(PAGE_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .kick(kick), .busy(busy),
    .num_of_words(num_of_words), .memory_offset(memory_offset),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_bytes(rd_bytes), .rd_done(rd_done),
    .s_if(s_if),
    .eng_we(eng_we), .eng_din(eng_din), .eng_full(eng_full), .eng_kick(eng_kick),
    .eng_data_num(eng_data_num),
`ifdef BATCH_CTRL_PERF_EN
    .perf_beats(perf_beats), .perf_batches(perf_batches),
`endif
    .eng_busy(eng_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [KEY_W+31:0] exp_wr[$];
  int unsigned       exp_kick[$];
  logic [95:0]       exp_rd[$];
  logic [DATA_W-1:0] beats[$];
  int                src_sent = 0;
  int                src_granted = 0;
  int                busy_cnt = 0;
  int                wr_seen = 0;
  int                full_mode = 0;
  int                valid_pct = 100;
  int unsigned       job_beats = 0;
  int unsigned       job_kicks = 0;

  // Observe everything on the falling edge: values here are what the next rising edge commits.
  always @(negedge clk) begin
    if (reset) begin
      src_sent    = 0;
      src_granted = 0;
      busy_cnt    = 0;
    end else begin
      if (kick && !busy) begin
        src_sent    = 0;
        src_granted = 0;
      end
      if (eng_we) begin
        check_val("we_while_full", eng_full, 0);
        if (exp_wr.size() == 0) check_val("wr_unexpected", eng_we, 0);
        else check_val("wr_din", eng_din, exp_wr.pop_front());
        wr_seen++;
      end
      if (eng_kick) begin
        if (exp_kick.size() == 0) check_val("kick_unexpected", eng_kick, 0);
        else check_val("kick_data_num", eng_data_num, exp_kick.pop_front());
        busy_cnt = $urandom_range(0, 4);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (rd_start) begin
        if (exp_rd.size() == 0) check_val("rd_unexpected", rd_start, 0);
        else check_val("rd_addr_bytes", {rd_addr, rd_bytes}, exp_rd.pop_front());
        src_granted += int'(rd_bytes / BEAT_BYTES);
      end
      if (s_if.s_valid && s_if.s_ready) src_sent++;
    end
  end

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_busy = (busy_cnt > 0);
      case (full_mode)
        1:       eng_full = 1'($urandom_range(0, 1));
        2:       eng_full = ~eng_full;
        default: eng_full = 1'b0;
      endcase
      if (src_sent < src_granted && src_sent < beats.size() &&
          $urandom_range(0, 99) < valid_pct) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = beats[src_sent];
      end else begin
        s_if.s_valid = 1'b0;
      end
    end
  end

  // Reference: keys are numbered across the job; key i is lane i%LANES of beat i/LANES.
  task automatic build_model(input int unsigned n, input logic [63:0] off);
    logic [DATA_W-1:0] b;
    int unsigned       left, sz;
    longint unsigned   total, sent, chunk;
    job_beats = (n + LANES - 1) / LANES;
    job_kicks = 0;
    beats.delete();
    for (int i = 0; i < int'(job_beats); i++) begin
      for (int w = 0; w < int'(DATA_W / 32); w++) b[w*32 +: 32] = $urandom;
      beats.push_back(b);
    end
    for (int i = 0; i < int'(n); i++) begin
      b = beats[i / LANES];
      exp_wr.push_back({32'(i), b[(i % LANES)*KEY_W +: KEY_W]});
    end
    left = n;
    while (left > 0) begin
      sz = (left > MAX_WORDS) ? MAX_WORDS : left;
      exp_kick.push_back(sz);
      job_kicks++;
      left -= sz;
    end
    total = longint'(job_beats) * BEAT_BYTES;
    sent  = 0;
    while (sent < total) begin
      chunk = (total - sent > PAGE_BYTES) ? PAGE_BYTES : total - sent;
      exp_rd.push_back({off + sent, 32'(chunk)});
      sent += chunk;
    end
  endtask

  task automatic start_job(input int unsigned n, input logic [63:0] off);
    @(posedge clk);
    #1;
    kick          = 1'b1;
    num_of_words  = n;
    memory_offset = off;
    @(posedge clk);
    #1;
    kick = 1'b0;
  endtask

  task automatic run_job(input int unsigned n, input logic [63:0] off, input int fm,
                         input int vp, input bit extra_kick);
    int busy_cycles;
    build_model(n, off);
    full_mode = fm;
    valid_pct = vp;
    start_job(n, off);
    busy_cycles = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      // a second kick mid-job must be ignored
      if (extra_kick && busy_cycles == 8) begin
        kick          = 1'b1;
        num_of_words  = 3;
        memory_offset = '1;
      end else begin
        kick = 1'b0;
      end
    end
    kick = 1'b0;
    check_val("job_done", busy, 0);
    check_val("wr_missing", exp_wr.size(), 0);
    check_val("kick_missing", exp_kick.size(), 0);
    check_val("rd_missing", exp_rd.size(), 0);
    if (n == 0) check_val("busy_len_1_2", (busy_cycles >= 1 && busy_cycles <= 2), 1);
`ifdef BATCH_CTRL_PERF_EN
    check_val("perf_beats", perf_beats, job_beats);
    check_val("perf_batches", perf_batches, job_kicks);
`endif
    exp_wr.delete();
    exp_kick.delete();
    exp_rd.delete();
  endtask

  initial begin
    int target;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_rd_start", rd_start, 0);
    check_val("rst_s_ready", s_if.s_ready, 0);
    check_val("rst_eng_we", eng_we, 0);
    check_val("rst_eng_kick", eng_kick, 0);
    #1 reset = 1'b0;

    run_job(0, 64'h40, 0, 100, 1'b0);
    run_job(16, 64'h1000, 0, 100, 1'b0);
    run_job(37, 64'h2000, 1, 50, 1'b1);
    run_job(100, 64'h0, 0, 100, 1'b0);
    run_job(300, 64'h10000, 0, 100, 1'b0);
    run_job(50, 64'h3000, 2, 30, 1'b0);

    // abandon a job while it is emitting keys
    build_model(64, 64'h8000);
    full_mode = 1;
    valid_pct = 80;
    target    = wr_seen + 5;
    start_job(64, 64'h8000);
    for (int c = 0; c < 2000 && wr_seen < target; c++) @(negedge clk);
    check_val("rst_reached_emit", wr_seen >= target, 1);
    reset = 1'b1;
    exp_wr.delete();
    exp_kick.delete();
    exp_rd.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_mid_busy", busy, 0);
    run_job(4, 64'h500, 0, 100, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_job($urandom_range(1, 90), {48'd0, 10'($urandom_range(0, 1023)), 6'd0},
              int'($urandom_range(0, 2)), int'($urandom_range(20, 100)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
